// File: rtl/cutelock_pkg.sv
// Shared helpers and mode encodings for the Cute-Lock key-sequence wrappers.
package cutelock_pkg;

   localparam int unsigned MAX_TABLE_W = 1024;
   localparam int unsigned MAX_KEY_W   = 32;

   typedef enum int unsigned {
      ADV_FREE  = 0,
      ADV_GATED = 1
   } adv_mode_e;

   typedef enum int unsigned {
      DECOY_EXT = 0,
      DECOY_INV = 1
   } decoy_mode_e;

   // Counter width: max(1, clog2(n)) so a single-key lock still has a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic logic [MAX_KEY_W-1:0] key_at(input logic [MAX_TABLE_W-1:0] tbl,
                                                    input int unsigned idx,
                                                    input int unsigned kb);
      logic [MAX_TABLE_W-1:0] w_sh;
      logic [MAX_KEY_W-1:0]   w_mask;
      w_sh   = tbl >> (idx * kb);
      w_mask = (MAX_KEY_W'(1) << kb) - MAX_KEY_W'(1);
      return MAX_KEY_W'(w_sh) & w_mask;
   endfunction

endpackage

// File: rtl/cutelock_mod_counter.sv
// Modulo-NUM_KEYS sequence counter with optional gated advance and explicit wrap.
module cutelock_mod_counter
   import cutelock_pkg::*;
#(
   parameter int unsigned NUM_KEYS     = 4,
   parameter int unsigned ADVANCE_MODE = 0
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             advance,
   output logic [cnt_width(NUM_KEYS)-1:0]   cnt
);

   localparam int unsigned      CNT_W = cnt_width(NUM_KEYS);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_KEYS - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_step;
   logic             w_in_range;

   assign w_step = (ADVANCE_MODE == ADV_GATED) ? advance : 1'b1;

   // Only non-power-of-two key counts leave unused codes to recover from.
   generate
      if ((32'd1 << CNT_W) == NUM_KEYS) begin : g_full
         assign w_in_range = 1'b1;
      end else begin : g_partial
         assign w_in_range = (r_cnt <= LAST);
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!w_in_range) begin
         r_cnt <= '0;
      end else if (w_step) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/cutelock_keyseq_reg.sv
// Time-varying key-gated output register: registers d_func only when key_in
// matches the key currently selected by the sequence counter, else a decoy.
module cutelock_keyseq_reg
   import cutelock_pkg::*;
#(
   parameter int unsigned                    W            = 1,
   parameter int unsigned                    KEY_BITS     = 3,
   parameter int unsigned                    NUM_KEYS     = 4,
   parameter logic [NUM_KEYS*KEY_BITS-1:0]   KEY_TABLE    = 12'hB1A,
   parameter int unsigned                    ADVANCE_MODE = 0,
   parameter int unsigned                    DECOY_MODE   = 0,
   parameter logic [W-1:0]                   RESET_VAL    = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [KEY_BITS-1:0] key_in,
   input  logic                advance,
   input  logic [W-1:0]        d_func,
   input  logic [W-1:0]        d_decoy,
   output logic [W-1:0]        q
);

   localparam int unsigned CNT_W = cnt_width(NUM_KEYS);
   localparam int unsigned ROM_N = 32'd1 << CNT_W;

   logic [KEY_BITS-1:0] w_key_rom [ROM_N];
   logic [CNT_W-1:0]    w_cnt;
   logic                w_match;
   logic [W-1:0]        w_decoy;
   logic [W-1:0]        r_q;

   // Unused counter codes alias entry 0 so the compare never sees X.
   generate
      for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
         localparam int unsigned IDX = (gi < NUM_KEYS) ? gi : 0;
         assign w_key_rom[gi] = KEY_BITS'(key_at(MAX_TABLE_W'(KEY_TABLE), IDX, KEY_BITS));
      end
   endgenerate

   cutelock_mod_counter #(
      .NUM_KEYS     (NUM_KEYS),
      .ADVANCE_MODE (ADVANCE_MODE)
   ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .advance (advance),
      .cnt     (w_cnt)
   );

   assign w_match = (key_in == w_key_rom[w_cnt]);
   assign w_decoy = (DECOY_MODE == DECOY_INV) ? ~d_func : d_decoy;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_q <= RESET_VAL;
      end else begin
         r_q <= w_match ? d_func : w_decoy;
      end
   end

   assign q = r_q;

endmodule
